// File: rtl/apb_gpio_slave_if.sv
// APB3 bus bundle shared by the GPIO slave front-end and its master.
interface apb_gpio_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_gpio_slave.sv
// APB3 slave front-end for the GPIO register block.
// A setup phase latches address, data and direction. The access phase then
// runs 1+WAIT_STATES wait cycles followed by one response cycle. Unaligned or
// unmapped accesses answer with PSLVERR and never reach the register block.
// Every output comes straight from a flop.
module apb_gpio_slave #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned NUM_REGS    = 10
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    apb_gpio_slave_if.slave apb,
    output logic [31:0]     gpio_addr,
    output logic [31:0]     gpio_dat_i,
    output logic            gpio_we,
    input  logic [31:0]     gpio_dat_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] MAP_LIMIT = 32'(NUM_REGS * 4);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    // An address is rejected when it is not word aligned or lies past the last register.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= MAP_LIMIT);
    endfunction

    state_t      state_r,   state_s;
    logic [3:0]  cnt_r,     cnt_s;
    logic [31:0] addr_r,    addr_s;
    logic [31:0] wdat_r,    wdat_s;
    logic [31:0] rdata_r,   rdata_s;
    logic [31:0] prdata_r,  prdata_s;
    logic        wr_r,      wr_s;
    logic        err_r,     err_s;
    logic        pready_r,  pready_s;
    logic        pslverr_r, pslverr_s;
    logic        we_r,      we_s;

    // Next-state and next-output logic. Response outputs are computed on the
    // way into RESP, so their flops present them during RESP only.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_s    = addr_r;
        wdat_s    = wdat_r;
        rdata_s   = rdata_r;
        wr_s      = wr_r;
        err_s     = err_r;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = 32'h0000_0000;
        we_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // PENABLE without a preceding setup is ignored.
                if (apb.PSEL && !apb.PENABLE) begin
                    addr_s  = apb.PADDR;
                    wdat_s  = apb.PWDATA;
                    wr_s    = apb.PWRITE;
                    err_s   = addr_err(apb.PADDR);
                    cnt_s   = WAIT_LOAD;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WAIT: begin
                rdata_s = err_r ? 32'h0000_0000 : gpio_dat_o;
                if (!apb.PSEL) begin
                    // The master abandoned the transfer, so drop it silently.
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s   = ST_RESP;
                    pready_s  = 1'b1;
                    pslverr_s = err_r;
                    prdata_s  = wr_r ? 32'h0000_0000 : rdata_s;
                    we_s      = wr_r & ~err_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end

            ST_RESP: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything and drops any transfer in flight.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= 32'h0000_0000;
            wdat_r    <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            prdata_r  <= 32'h0000_0000;
            wr_r      <= 1'b0;
            err_r     <= 1'b0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            we_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            addr_r    <= addr_s;
            wdat_r    <= wdat_s;
            rdata_r   <= rdata_s;
            prdata_r  <= prdata_s;
            wr_r      <= wr_s;
            err_r     <= err_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            we_r      <= we_s;
        end
    end

    assign apb.PREADY  = pready_r;
    assign apb.PSLVERR = pslverr_r;
    assign apb.PRDATA  = prdata_r;
    assign gpio_addr   = addr_r;
    assign gpio_dat_i  = wdat_r;
    assign gpio_we     = we_r;

endmodule

// File: doc/apb_gpio_slave.md
Name: apb_gpio_slave

Overview:
- APB3 slave front-end that sits directly upstream of the GPIO register block.
- Converts APB setup/access transfers into the register block's simple bus: gpio_addr, gpio_dat_i, a single-cycle gpio_we strobe, and read data captured from gpio_dat_o.
- Inserts a fixed, programmable number of wait states.
- Flags accesses to unmapped or unaligned addresses with PSLVERR and suppresses them.

Parameters:
- WAIT_STATES, 0, extra access-phase cycles before PREADY (range 0..15).
- NUM_REGS, 10, number of mapped 32-bit registers at word offsets 0x00..(NUM_REGS-1)*4 (RGPIO_IN 0x00 through RGPIO_NEC 0x24).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  reset, synchronous, active-low.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB enable (access phase).
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address.
- PWDATA  input  32  write data.
- PREADY  output  1  transfer complete.
- PRDATA  output  32  read data, valid while PREADY=1 and PWRITE=0.
- PSLVERR  output  1  error response, valid while PREADY=1.
- gpio_addr  output  32  address to the register block.
- gpio_dat_i  output  32  write data to the register block.
- gpio_we  output  1  one-cycle write strobe to the register block.
- gpio_dat_o  input  32  combinational read data from the register block for the current gpio_addr.

Behaviour:
- Reset: synchronous; sys_rst=0 sampled at a rising edge. All outputs go to 0 and the FSM goes to IDLE. A transfer in flight when reset is taken is dropped; no gpio_we is issued.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Setup is detected when PSEL=1 and PENABLE=0.
  - On setup: latch PADDR into gpio_addr, PWDATA into gpio_dat_i, PWRITE into wr_q, and err_q.
  - err_q = (PADDR[1:0]!=0) or (PADDR >= NUM_REGS*4).
  - Load cnt = WAIT_STATES, then go to WAIT.
- WAIT:
  - Each cycle, rdata_q <= err_q ? 0 : gpio_dat_o.
  - If cnt==0, go to RESP; otherwise decrement cnt.
  - If PSEL=0 in any WAIT cycle (protocol abort), return to IDLE with no write and no response.
- RESP (exactly one cycle):
  - PREADY=1.
  - PSLVERR=err_q.
  - PRDATA = wr_q ? 0 : rdata_q.
  - gpio_we = wr_q & ~err_q.
  - Next state is always IDLE.
- Latency: setup cycle, then 1+WAIT_STATES access cycles with PREADY=0, then one cycle with PREADY=1. The access phase is 2+WAIT_STATES cycles.
- Write strobe: gpio_we is high only in RESP, coincident with PREADY. The register block captures on the edge that ends RESP. gpio_addr and gpio_dat_i stay stable from the first WAIT cycle through RESP.
- Hold between transfers: gpio_addr and gpio_dat_i hold their last values in IDLE. gpio_we, PREADY and PSLVERR are 0 outside RESP.
- Back-to-back transfers: a new setup phase may be presented in the cycle after RESP; IDLE accepts it. Minimum transfer period is 3+WAIT_STATES cycles.
- Ignored stimulus: PENABLE=1 seen in IDLE (setup never seen) is ignored and no response is given. PSEL/PWRITE/PADDR/PWDATA changes during WAIT are ignored (latched values are used).
- Error transfers: the register block sees no write. The read response is 0 with PSLVERR=1.

Test Plan:
- Reset and mapped write/read:
  - Hold sys_rst=0 for 2 cycles, then release.
  - Check all outputs are 0.
  - APB write 0xAAAA5555 to 0x04: gpio_we high exactly 1 cycle with gpio_addr=0x04 and gpio_dat_i=0xAAAA5555, PSLVERR=0.
  - APB read 0x04: PRDATA=0xAAAA5555.
- Wait-state latency:
  - Run with WAIT_STATES=0 and with WAIT_STATES=3, back-to-back write/read to 0x08 of 0xFFFF0000.
  - PREADY must rise exactly 2 and 5 access cycles after PENABLE, respectively.
- Error response:
  - Write 0x12345678 to 0x7A (unaligned) and to 0x28 (unmapped).
  - Required: PSLVERR=1 with PREADY, gpio_we never asserted, read of 0x28 returns PRDATA=0.
- Input path:
  - Model drives gpio_dat_o=0xDEADBEEF when gpio_addr=0x00.
  - APB read 0x00 returns 0xDEADBEEF with PSLVERR=0.
- Abort and reset mid-transfer:
  - Drop PSEL during WAIT (WAIT_STATES=3) on a write to 0x10: no gpio_we, no PREADY, FSM back in IDLE.
  - Assert sys_rst=0 during WAIT of a write to 0x14: no gpio_we, and after release a fresh read of 0x14 completes normally.
